// File: rtl/pixel_clk_pkg.sv
// pixel_clk_pkg: shared FSM state type and divisor defaults for pixel timing blocks
package pixel_clk_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam int MIN_DIV = 2;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_DIV = 4;
endpackage

// File: rtl/pixel_clk_gen_if.sv
// pixel_clk_gen_if: control/status bundle of the pixel timing generator
//   master drives enable, div_load, div_value; slave drives pix_en, pix_clk,
//   running, div_cur, load_pend, load_err
interface pixel_clk_gen_if #(parameter int CNT_W = pixel_clk_pkg::DEF_CNT_W);
  logic enable;
  logic div_load;
  logic [CNT_W-1:0] div_value;
  logic pix_en;
  logic pix_clk;
  logic running;
  logic [CNT_W-1:0] div_cur;
  logic load_pend;
  logic load_err;
  modport master (
    output enable, div_load, div_value,
    input pix_en, pix_clk, running, div_cur, load_pend, load_err
  );
  modport slave (
    input enable, div_load, div_value,
    output pix_en, pix_clk, running, div_cur, load_pend, load_err
  );
endinterface

// File: rtl/div_shadow_reg.sv
// div_shadow_reg: active/pending divisor pair, applied only on period boundaries
//   clock, reset (async active-low); load/value: divisor request;
//   boundary: wrap cycle; idle: generator stopped
//   div_act: active divisor; pend_v: pending valid; err: one-cycle reject pulse
module div_shadow_reg
  import pixel_clk_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             boundary,
  input  logic             idle,
  output logic [CNT_W-1:0] div_act,
  output logic             pend_v,
  output logic             err
);
  logic [CNT_W-1:0] div_pend;
  logic ok, direct;
  assign ok = load && (value >= CNT_W'(MIN_DIV));
  // a fresh load on a boundary (or while stopped) wins over any pending value
  assign direct = ok && (idle || boundary);
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_act <= CNT_W'(DEFAULT_DIV);
      div_pend <= '0;
      pend_v <= 1'b0;
      err <= 1'b0;
    end else begin
      div_act <= direct ? value : (boundary && pend_v) ? div_pend : div_act;
      div_pend <= ok ? value : div_pend;
      pend_v <= (ok && !direct) || (pend_v && !boundary);
      err <= load && !ok;
    end
  end
endmodule

// File: rtl/pixel_clk_gen.sv
// pixel_clk_gen: programmable-divisor pixel enable strobe and square-wave pixel clock
//   clock, reset (async active-low); bus: pixel_clk_gen_if slave
//   (enable/div_load/div_value in; pix_en/pix_clk/running/div_cur/load_pend/load_err out)
module pixel_clk_gen
  import pixel_clk_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input logic clock,
  input logic reset,
  pixel_clk_gen_if.slave bus
);
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, div_act;
  logic [CNT_W:0] half;
  logic wrap, pend_v, err, pix_clk_q;
  div_shadow_reg #(.CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) u_div (
    .clock(clock),
    .reset(reset),
    .load(bus.div_load),
    .value(bus.div_value),
    .boundary(wrap),
    .idle(state == IDLE),
    .div_act(div_act),
    .pend_v(pend_v),
    .err(err)
  );
  assign wrap = (state != IDLE) && (cnt == div_act - 1'b1);
  always_comb begin
    state_nxt = state;
    cnt_nxt = '0;
    half = '0;
    state_nxt = (state == IDLE) ? (bus.enable ? RUN : IDLE) :
                bus.enable ? RUN : (state == DRAIN && wrap) ? IDLE : DRAIN;
    cnt_nxt = (state == IDLE || state_nxt == IDLE || wrap) ? '0 : cnt + 1'b1;
    half = ({1'b0, div_act} + 1'b1) >> 1;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  end
  // div_act only changes when cnt_nxt is 0, where the comparison holds for any N>=2,
  // so the current divisor gives the same result as the next one
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      pix_clk_q <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      pix_clk_q <= (state_nxt != IDLE) && ({1'b0, cnt_nxt} < half);
    end
  end
  assign bus.pix_en = wrap;
  assign bus.pix_clk = pix_clk_q;
  assign bus.running = state != IDLE;
  assign bus.div_cur = div_act;
  assign bus.load_pend = pend_v;
  assign bus.load_err = err;
endmodule

// File: tb/tb_pixel_clk_gen.sv
// tb_pixel_clk_gen: directed self-checking bench for pixel_clk_gen
module tb_pixel_clk_gen;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  pixel_clk_gen_if #(.CNT_W(8)) bus ();
  pixel_clk_gen #(.CNT_W(8), .DEFAULT_DIV(4)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );
  always #5 clock = ~clock;
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic load(input logic [7:0] v);
    bus.div_load = 1'b1;
    bus.div_value = v;
  endtask
  initial begin
    bus.enable = 1'b0;
    bus.div_load = 1'b0;
    bus.div_value = '0;
    tick;
    tick;
    chk("rst_pix_en", bus.pix_en, 0);
    chk("rst_pix_clk", bus.pix_clk, 0);
    chk("rst_running", bus.running, 0);
    chk("rst_div_cur", bus.div_cur, 4);
    chk("rst_load_pend", bus.load_pend, 0);
    chk("rst_load_err", bus.load_err, 0);
    reset = 1'b1;
    tick;
    chk("idle_running", bus.running, 0);
    // default divisor 4
    bus.enable = 1'b1;
    tick;
    chk("start_running", bus.running, 1);
    for (int i = 1; i <= 12; i++) begin
      chk($sformatf("n4_en_%0d", i), bus.pix_en, (i % 4) == 0);
      chk($sformatf("n4_clk_%0d", i), bus.pix_clk, ((i - 1) % 4) < 2);
      tick;
    end
    // drain: drop enable at cnt=1
    tick;
    bus.enable = 1'b0;
    tick;
    chk("drain_running", bus.running, 1);
    chk("drain_en_c2", bus.pix_en, 0);
    tick;
    chk("drain_final_en", bus.pix_en, 1);
    tick;
    chk("drain_idle_running", bus.running, 0);
    chk("drain_idle_clk", bus.pix_clk, 0);
    chk("drain_idle_en", bus.pix_en, 0);
    // odd divisor loaded in IDLE
    load(5);
    tick;
    bus.div_load = 1'b0;
    chk("idle_load_div", bus.div_cur, 5);
    chk("idle_load_pend", bus.load_pend, 0);
    bus.enable = 1'b1;
    tick;
    for (int i = 1; i <= 10; i++) begin
      chk($sformatf("n5_en_%0d", i), bus.pix_en, (i % 5) == 0);
      chk($sformatf("n5_clk_%0d", i), bus.pix_clk, ((i - 1) % 5) < 3);
      tick;
    end
    // re-enable during drain keeps phase
    tick;
    bus.enable = 1'b0;
    tick;
    bus.enable = 1'b1;
    tick;
    chk("reen_running", bus.running, 1);
    chk("reen_clk_c3", bus.pix_clk, 0);
    tick;
    chk("reen_en_c4", bus.pix_en, 1);
    tick;
    chk("reen_en_c0", bus.pix_en, 0);
    chk("reen_clk_c0", bus.pix_clk, 1);
    // pending load in RUN applies after the next wrap
    load(4);
    tick;
    bus.div_load = 1'b0;
    chk("run_load_pend", bus.load_pend, 1);
    chk("run_load_div_old", bus.div_cur, 5);
    tick;
    tick;
    tick;
    chk("run_load_wrap_en", bus.pix_en, 1);
    chk("run_load_wrap_pend", bus.load_pend, 1);
    tick;
    chk("run_load_div_new", bus.div_cur, 4);
    chk("run_load_pend_clr", bus.load_pend, 0);
    // last pending wins: 6 at cnt1, 3 at cnt2
    tick;
    load(6);
    tick;
    chk("lw_pend", bus.load_pend, 1);
    load(3);
    tick;
    bus.div_load = 1'b0;
    chk("lw_wrap_en", bus.pix_en, 1);
    chk("lw_div_still4", bus.div_cur, 4);
    tick;
    chk("lw_div3", bus.div_cur, 3);
    chk("lw_pend_clr", bus.load_pend, 0);
    chk("lw_en_c0", bus.pix_en, 0);
    tick;
    chk("lw_en_c1", bus.pix_en, 0);
    tick;
    chk("lw_en_c2", bus.pix_en, 1);
    chk("lw_clk_c2", bus.pix_clk, 0);
    tick;
    // load 2 exactly on wrap bypasses pending
    tick;
    tick;
    chk("wl_wrap_en", bus.pix_en, 1);
    load(2);
    tick;
    bus.div_load = 1'b0;
    chk("wl_div2", bus.div_cur, 2);
    chk("wl_no_pend", bus.load_pend, 0);
    chk("wl_en_c0", bus.pix_en, 0);
    chk("wl_clk_c0", bus.pix_clk, 1);
    tick;
    chk("wl_en_c1", bus.pix_en, 1);
    chk("wl_clk_c1", bus.pix_clk, 0);
    tick;
    chk("wl_en_c0b", bus.pix_en, 0);
    chk("wl_clk_c0b", bus.pix_clk, 1);
    // rejected loads
    load(1);
    tick;
    chk("rej1_err", bus.load_err, 1);
    chk("rej1_div", bus.div_cur, 2);
    chk("rej1_pend", bus.load_pend, 0);
    load(0);
    tick;
    bus.div_load = 1'b0;
    chk("rej0_err", bus.load_err, 1);
    chk("rej0_div", bus.div_cur, 2);
    tick;
    chk("rej_err_clr", bus.load_err, 0);
    chk("rej_wrap_en", bus.pix_en, 1);
    // reset mid-period with a pending load
    load(5);
    tick;
    bus.div_load = 1'b0;
    chk("mr_div5", bus.div_cur, 5);
    tick;
    load(6);
    tick;
    bus.div_load = 1'b0;
    chk("mr_pend", bus.load_pend, 1);
    chk("mr_clk_c2", bus.pix_clk, 1);
    reset = 1'b0;
    #1;
    chk("mr_running", bus.running, 0);
    chk("mr_pix_clk", bus.pix_clk, 0);
    chk("mr_pix_en", bus.pix_en, 0);
    chk("mr_div_cur", bus.div_cur, 4);
    chk("mr_load_pend", bus.load_pend, 0);
    chk("mr_load_err", bus.load_err, 0);
    bus.enable = 1'b0;
    tick;
    reset = 1'b1;
    tick;
    tick;
    chk("post_rst_running", bus.running, 0);
    chk("post_rst_div", bus.div_cur, 4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pixel_clk_gen.md
# pixel_clk_gen

Parametrised pixel-timing generator replacing the fixed divide-by-8 pixel clock. From the single system clock it produces a one-cycle pixel enable strobe and a matching square-wave pixel clock. The divisor is programmable at run time and is changed only on period boundaries. It sits between the board clock and the horizontal/vertical sync counters, which advance on `pix_en`; no derived clock is used as an edge source.

## Interface
- `CNT_W`, 8: width of the divisor and period counter.
- `DEFAULT_DIV`, 4: active divisor after reset; must be in 2..2^CNT_W-1.

- `clock`  in  1  system clock; every register is clocked on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run request.
- `div_load`  in  1  one-cycle strobe that captures `div_value`.
- `div_value`  in  CNT_W  requested divisor N.
- `pix_en`  out  1  one-cycle strobe, once per period, in the last cycle of each period.
- `pix_clk`  out  1  registered square wave with period N.
- `running`  out  1  high in RUN and DRAIN.
- `div_cur`  out  CNT_W  active divisor.
- `load_pend`  out  1  a divisor is pending and waiting for a boundary.
- `load_err`  out  1  registered one-cycle pulse when a load is rejected.

## Operation
- Registers:
  - `cnt` counts 0..N-1.
  - `div_act` holds N.
  - `div_pend` and `pend_v` hold the pending divisor.
  - FSM state is IDLE, RUN or DRAIN.
- Wrap cycle: `cnt==div_act-1` while in RUN or DRAIN. `pix_en` = wrap, decoded from registers with no input dependence.
- FSM transitions:
  - IDLE to RUN: on `enable=1`. In the next cycle `cnt=0`.
  - RUN to DRAIN: on `enable=0`. Counting continues.
  - DRAIN to RUN: on `enable=1`. No phase disturbance.
  - DRAIN to IDLE: on a wrap cycle with `enable=0`. The final `pix_en` is emitted. In the next cycle `cnt=0` and `pix_clk=0`.
  - In IDLE, `cnt` holds 0.
- Divisor loads:
  - A load with `div_value<2` is rejected. `load_err` pulses in the next cycle. Pending state is unchanged.
  - A valid load in IDLE goes directly to `div_act` in the next cycle.
  - A valid load in RUN or DRAIN sets `div_pend` and `pend_v`. A later load overwrites the pending value (last wins).
  - On a wrap cycle, a pending value moves into `div_act`, `pend_v` clears, and the next period uses the new N.
  - A valid load presented on a wrap cycle itself bypasses pending and takes effect for the next period.
  - A load in the same cycle as a DRAIN-to-IDLE transition is applied to `div_act`.
- `pix_clk`:
  - Next value = (next state is RUN or DRAIN) && (`cnt_next` < ceil(`div_act_next`/2)).
  - High for ceil(N/2) cycles, then low for floor(N/2) cycles.
  - Rising edge is aligned with `cnt` going to 0.
- Arithmetic: `cnt` increments modulo `div_act` and never exceeds `div_act-1`. ceil(N/2) is computed as (N+1)>>1 at CNT_W+1 bits.
- Reset values:
  - `cnt=0`, `div_act=DEFAULT_DIV`, `pend_v=0`, state IDLE.
  - `pix_en=0`, `pix_clk=0`, `running=0`, `load_err=0`, `load_pend=0`, `div_cur=DEFAULT_DIV`.
- Asserting reset mid-period clears everything immediately and discards any pending divisor.

## Timing
- `enable` rises in cycle t while IDLE:
  - t+1: `running=1`, `cnt=0`, `pix_clk=1`.
  - First `pix_en` at t+N, then every N cycles.
- Load latency:
  - IDLE: `div_cur` updates at t+1.
  - RUN: `div_cur` updates in the cycle after the next wrap. `load_pend` is high from t+1 until that cycle.
- Stop: `running` falls in the cycle after the final `pix_en`. No partial period is ever emitted.
- Throughput: at N=2, `pix_en` is high every other cycle and `pix_clk` toggles every cycle.
- `load_err` is high for exactly one cycle per rejected load.

## Structure
- Shared package `pixel_clk_pkg`:
  - state enum (IDLE, RUN, DRAIN);
  - `MIN_DIV=2`;
  - default `CNT_W` and `DEFAULT_DIV`, reused by the sync generators.
- One sub-module, `div_shadow_reg`. It contains `div_act`, `div_pend` and `pend_v`, the validity check and the apply-at-boundary logic. Its inputs are `load`, `value`, `boundary` and `idle`. Its outputs are `div_act`, `pend_v` and `err`.
- The FSM, counter and `pix_clk` logic live in the top module.

## Test plan
- Reset and run at default divisor: release reset, raise `enable`.
  - Required: `pix_en` at cycles 4, 8, 12 after enable.
  - Required: `pix_clk` pattern 1,1,0,0 repeating.
- Odd divisor: load 5 in IDLE, then enable.
  - Required: `div_cur=5`.
  - Required: `pix_clk` 1,1,1,0,0 repeating, with `pix_en` on the fifth cycle of each period.
- Boundary-aligned change: in RUN at N=4, load 6 at `cnt=1`, then load 3 at `cnt=2`.
  - Required: `load_pend=1`.
  - Required: the current period ends at 4 cycles, the next period lasts 3 cycles, and the value 6 is never used.
- Loads on the wrap cycle and rejected loads:
  - Load 2 exactly on the wrap cycle. Required: the immediately following period is 2 cycles.
  - Load 1, then load 0. Required: `load_err` pulses once for each, and `div_cur` is unchanged.
- Drain and re-enable:
  - Drop `enable` at `cnt=1` with N=4. Required: `pix_en` still fires at `cnt=3`, then IDLE.
  - Re-raise `enable` during DRAIN. Required: the period is uninterrupted.
- Reset mid-operation: assert reset at `cnt=2` with a load pending.
  - Required: all outputs return to their reset values immediately.
  - Required: `div_cur=DEFAULT_DIV` and `load_pend=0`.
